// File: rtl/bcd_time_counter.sv
// mm:ss BCD stopwatch with start/stop, clear and optional tick prescaler.
// Optional HOURS_EN macro adds HR_TENS:HR_ONES digits, wrapping after HR_MAX:59:59.
module bcd_time_counter #(
    parameter int unsigned PRESCALE = 1
`ifdef HOURS_EN
    , parameter int unsigned HR_MAX = 23
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       START_STOP,
    input  logic       CLEAR,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] MIN_TENS,
    output logic       RUNNING,
    output logic       ROLLOVER
`ifdef HOURS_EN
    , output logic [3:0] HR_ONES
    , output logic [3:0] HR_TENS
`endif
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef HOURS_EN
    localparam logic [3:0] HR_TENS_MAX = 4'(HR_MAX / 10);
    localparam logic [3:0] HR_ONES_MAX = 4'(HR_MAX % 10);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [3:0]      min_ones_q, min_ones_d;
    logic [3:0]      min_tens_q, min_tens_d;
    logic            running_q, running_d;
    logic            rollover_q, rollover_d;
`ifdef HOURS_EN
    logic [3:0]      hr_ones_q, hr_ones_d;
    logic [3:0]      hr_tens_q, hr_tens_d;
`endif

    logic            advance_c;

    // State and time registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
`ifdef HOURS_EN
            hr_ones_q  <= '0;
            hr_tens_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
`ifdef HOURS_EN
            hr_ones_q  <= hr_ones_d;
            hr_tens_q  <= hr_tens_d;
`endif
        end
    end

    // Next state, prescaler and BCD carry chain
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        rollover_d = 1'b0;
        advance_c  = 1'b0;
`ifdef HOURS_EN
        hr_ones_d  = hr_ones_q;
        hr_tens_d  = hr_tens_q;
`endif

        if (CLEAR) begin
            state_d    = S_IDLE;
            presc_d    = '0;
            sec_ones_d = '0;
            sec_tens_d = '0;
            min_ones_d = '0;
            min_tens_d = '0;
`ifdef HOURS_EN
            hr_ones_d  = '0;
            hr_tens_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START_STOP) state_d = S_RUN;
                end
                S_RUN: begin
                    if (TICK) begin
                        if (presc_q == PW'(PRESCALE - 1)) begin
                            presc_d   = '0;
                            advance_c = 1'b1;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                    if (START_STOP) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (START_STOP) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (advance_c) begin
            if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q != 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q != 4'd5) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
`ifdef HOURS_EN
                            if (hr_tens_q == HR_TENS_MAX && hr_ones_q == HR_ONES_MAX) begin
                                hr_ones_d  = 4'd0;
                                hr_tens_d  = 4'd0;
                                rollover_d = 1'b1;
                            end else if (hr_ones_q == 4'd9) begin
                                hr_ones_d = 4'd0;
                                hr_tens_d = hr_tens_q + 4'd1;
                            end else begin
                                hr_ones_d = hr_ones_q + 4'd1;
                            end
`else
                            rollover_d = 1'b1;
`endif
                        end
                    end
                end
            end
        end

        running_d = (state_d == S_RUN);
    end

    assign SEC_ONES = sec_ones_q;
    assign SEC_TENS = sec_tens_q;
    assign MIN_ONES = min_ones_q;
    assign MIN_TENS = min_tens_q;
    assign RUNNING  = running_q;
    assign ROLLOVER = rollover_q;
`ifdef HOURS_EN
    assign HR_ONES  = hr_ones_q;
    assign HR_TENS  = hr_tens_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: seconds-total model checked every cycle on two
// instances (PRESCALE=1 and PRESCALE=4), plus directed literal checks.
module tb_bcd_time_counter;

    logic CLK = 1'b0;
    logic RST, TICK, START_STOP, CLEAR;

    logic [3:0] so1, st1, mo1, mt1, so4, st4, mo4, mt4;
    logic       run1, roll1, run4, roll4;
`ifdef HOURS_EN
    logic [3:0] ho1, ht1, ho4, ht4;
    localparam int WRAP = 24 * 3600;
`else
    localparam int WRAP = 3600;
`endif

    always #5 CLK = ~CLK;

    bcd_time_counter #(.PRESCALE(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START_STOP(START_STOP), .CLEAR(CLEAR),
        .SEC_ONES(so1), .SEC_TENS(st1), .MIN_ONES(mo1), .MIN_TENS(mt1),
        .RUNNING(run1), .ROLLOVER(roll1)
`ifdef HOURS_EN
        , .HR_ONES(ho1), .HR_TENS(ht1)
`endif
    );

    bcd_time_counter #(.PRESCALE(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START_STOP(START_STOP), .CLEAR(CLEAR),
        .SEC_ONES(so4), .SEC_TENS(st4), .MIN_ONES(mo4), .MIN_TENS(mt4),
        .RUNNING(run4), .ROLLOVER(roll4)
`ifdef HOURS_EN
        , .HR_ONES(ho4), .HR_TENS(ht4)
`endif
    );

    // Model: state (0 idle, 1 run, 2 pause), prescaler, elapsed seconds, wrap pulse
    typedef struct {
        int st;
        int pre;
        int secs;
        bit roll;
    } mdl_t;

    mdl_t m1, m4;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    function automatic mdl_t mstep(mdl_t m, int p, bit t, bit s, bit c, bit r);
        mdl_t n = m;
        n.roll = 1'b0;
        if (r || c) begin
            n.st = 0; n.pre = 0; n.secs = 0;
        end else if (m.st == 1) begin
            if (t) begin
                n.pre = m.pre + 1;
                if (n.pre == p) begin
                    n.pre  = 0;
                    n.secs = m.secs + 1;
                    if (n.secs == WRAP) begin
                        n.secs = 0;
                        n.roll = 1'b1;
                    end
                end
            end
            if (s) n.st = 2;
        end else if (s) begin
            n.st = 1;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        m1 = mstep(m1, 1, TICK, START_STOP, CLEAR, RST);
        m4 = mstep(m4, 4, TICK, START_STOP, CLEAR, RST);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m,
                           input logic [3:0] so, input logic [3:0] st,
                           input logic [3:0] mo, input logic [3:0] mt,
                           input logic run, input logic roll);
        int s, mi;
        s  = m.secs % 60;
        mi = (m.secs / 60) % 60;
        check({tag, ".sec_ones"}, int'(so), s % 10);
        check({tag, ".sec_tens"}, int'(st), s / 10);
        check({tag, ".min_ones"}, int'(mo), mi % 10);
        check({tag, ".min_tens"}, int'(mt), mi / 10);
        check({tag, ".running"},  int'(run), (m.st == 1) ? 1 : 0);
        check({tag, ".rollover"}, int'(roll), int'(m.roll));
    endtask

    // Per-cycle model comparison
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp_dut("m1", m1, so1, st1, mo1, mt1, run1, roll1);
            cmp_dut("m4", m4, so4, st4, mo4, mt4, run4, roll4);
`ifdef HOURS_EN
            check("m1.hr_ones", int'(ho1), (m1.secs / 3600) % 10);
            check("m1.hr_tens", int'(ht1), (m1.secs / 3600) / 10);
            check("m4.hr_ones", int'(ho4), (m4.secs / 3600) % 10);
            check("m4.hr_tens", int'(ht4), (m4.secs / 3600) / 10);
`endif
        end
    end

    task automatic cyc(input bit t, input bit s, input bit c, input bit r);
        TICK = t; START_STOP = s; CLEAR = c; RST = r;
        @(negedge CLK);
        TICK = 1'b0; START_STOP = 1'b0; CLEAR = 1'b0; RST = 1'b0;
    endtask

    task automatic lit1(input string name, input int so, input int st, input int mo, input int mt,
                        input int run, input int roll);
        check({name, ".so"}, int'(so1), so);
        check({name, ".st"}, int'(st1), st);
        check({name, ".mo"}, int'(mo1), mo);
        check({name, ".mt"}, int'(mt1), mt);
        check({name, ".run"}, int'(run1), run);
        check({name, ".roll"}, int'(roll1), roll);
    endtask

    initial begin
        m1 = '{0, 0, 0, 1'b0};
        m4 = '{0, 0, 0, 1'b0};
        RST = 1'b1; TICK = 1'b0; START_STOP = 1'b0; CLEAR = 1'b0;
        @(negedge CLK);
        cyc(1, 0, 0, 1);
        chk_en = 1'b1;
        lit1("reset", 0, 0, 0, 0, 0, 0);
        check("reset.run4", int'(run4), 0);

        // Start, 5 seconds
        cyc(0, 1, 0, 0);
        repeat (5) cyc(1, 0, 0, 0);
        lit1("five_ticks", 5, 0, 0, 0, 1, 0);

        // 00:59 -> 01:00
        repeat (54) cyc(1, 0, 0, 0);
        lit1("at_00_59", 9, 5, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        lit1("to_01_00", 0, 0, 1, 0, 1, 0);

        // 59:59 -> wrap
        repeat (3539) cyc(1, 0, 0, 0);
        lit1("at_59_59", 9, 5, 9, 5, 1, 0);
        cyc(1, 0, 0, 0);
`ifdef HOURS_EN
        lit1("to_1h", 0, 0, 0, 0, 1, 0);
        check("to_1h.hr_ones", int'(ho1), 1);
`else
        lit1("wrap", 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        lit1("wrap_pulse_end", 0, 0, 0, 0, 1, 0);
`endif

        // Simultaneous START_STOP + TICK
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (7) cyc(1, 0, 0, 0);
        lit1("at_00_07", 7, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0);
        lit1("ss_tick_run", 8, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        lit1("paused_hold", 8, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        lit1("resume", 8, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        lit1("resume_tick", 9, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        lit1("ss_tick_pause", 9, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        lit1("to_00_10", 0, 1, 0, 0, 1, 0);

        // Prescaler on the PRESCALE=4 instance
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (7) cyc(1, 0, 0, 0);
        check("p4.seven_ticks", int'(so4), 1);
        cyc(0, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        check("p4.paused", int'(so4), 1);
        check("p4.paused_run", int'(run4), 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check("p4.resume_tick", int'(so4), 2);

        // CLEAR with TICK at 12:34, then RST mid-count
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (754) cyc(1, 0, 0, 0);
        lit1("at_12_34", 4, 3, 2, 1, 1, 0);
        cyc(1, 0, 1, 0);
        lit1("clear_tick", 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (10) cyc(1, 0, 0, 0);
        lit1("before_rst", 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1);
        lit1("rst_mid", 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        lit1("idle_ignores_tick", 0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
